// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control: opcodes, FSM
// state encoding and the two-bit ALU-op codes sent to the ALU-control decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR_I  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BEQEX   = 4'd8,
        ITYPEEX = 4'd9,
        ITYPEWB = 4'd10,
        JEX     = 4'd11
    } state_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] opc);
        return (opc == OP_ANDI) || (opc == OP_ORI);
    endfunction

endpackage

// File: rtl/mcycle_control.sv
// Multicycle MIPS main-control FSM: sequences datapath enables per instruction,
// drives aluop1/aluop0 to the ALU-control decoder and counts retired instructions.
module mcycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int   CNT_W    = 32,
    parameter logic MEM_WAIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             pcwritecond,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             irwrite,
    output logic             regdst,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsource,
    output logic             aluop1,
    output logic             aluop0,
    output logic             ext_zero,
    output logic             illegal_op,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state;
    state_t     state_nx;
    logic [5:0] op_q;
    logic       illegal_q;
    logic       mem_ok;
    logic       op_legal;
    logic [1:0] aluop;

    assign mem_ok     = MEM_WAIT ? mem_ready : 1'b1;
    assign illegal_op = illegal_q;
    assign aluop1     = aluop[1];
    assign aluop0     = aluop[0];

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI: op_legal = 1'b1;
            default:                  op_legal = 1'b0;
        endcase
    end

    // State, latched opcode, illegal-opcode pulse and the retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            op_q        <= 6'b000000;
            illegal_q   <= 1'b0;
            instr_count <= '0;
        end else begin
            state     <= state_nx;
            illegal_q <= (state == DECODE) && !op_legal;
            if (state == DECODE)
                op_q <= op;
            if (instr_done)
                instr_count <= instr_count + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FETCH:   state_nx = mem_ok ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_RTYPE:                  state_nx = RTYPEEX;
                    OP_LW, OP_SW:              state_nx = MEMADR;
                    OP_BEQ:                    state_nx = BEQEX;
                    OP_J:                      state_nx = JEX;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_nx = ITYPEEX;
                    default:                   state_nx = FETCH;
                endcase
            end
            MEMADR:  state_nx = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_nx = mem_ok ? MEMWB : MEMRD;
            MEMWB:   state_nx = FETCH;
            MEMWR:   state_nx = mem_ok ? FETCH : MEMWR;
            RTYPEEX: state_nx = ALUWB;
            ALUWB:   state_nx = FETCH;
            BEQEX:   state_nx = FETCH;
            ITYPEEX: state_nx = ITYPEWB;
            ITYPEWB: state_nx = FETCH;
            JEX:     state_nx = FETCH;
            default: state_nx = FETCH;
        endcase
    end

    // Moore decode, except FETCH's IR/PC loads and the sw retire which wait on memory.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        irwrite     = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsource    = 2'b00;
        aluop       = ALUOP_ADD;
        ext_zero    = 1'b0;
        instr_done  = 1'b0;
        case (state)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ok;
                pcwrite = mem_ok;
            end
            DECODE: begin
                alusrcb = 2'b11;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWR: begin
                memwrite   = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ok;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_RTYPE;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            BEQEX: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_BR_I;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
                instr_done  = 1'b1;
            end
            ITYPEEX: begin
                alusrca  = 1'b1;
                alusrcb  = 2'b10;
                aluop    = ALUOP_BR_I;
                ext_zero = is_zero_ext(op_q);
            end
            ITYPEWB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            JEX: begin
                pcwrite    = 1'b1;
                pcsource   = 2'b10;
                instr_done = 1'b1;
            end
            default: begin
                memread = 1'b0;
            end
        endcase
    end

endmodule
